vga_sprite_engine: RTL and testbench

VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

---
 rtl/vga_sprite_engine.sv | 196 +++++++++++++++++++
 tb/tb_vga_sprite_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_engine.sv
// rtl/vga_sprite_engine.sv - multi-channel sprite overlay engine with colour-key transparency
//
// Purpose: overlays up to NSPR fixed-size sprites onto a VGA raster. Software
// programs shadow registers over a write-only Avalon-MM port. The shadow
// registers are copied to the active set once per frame, at hcount==0,
// vcount==480. The pixel path is stage 0 (hit test + ROM address), then
// ROM_LAT ROM cycles, then a registered compose stage.
//
// Ports:
//   clk, reset                      clock; asynchronous active-high reset
//   chipselect, write, address,     register write port (no read path)
//   writedata
//   hcount, vcount, blank_n         raster position from the timing generator
//                                   (pixel column = hcount[10:1])
//   rom_addr                        per-channel sprite ROM addresses, channel i at slice i
//   rom_data                        per-channel RGB565 ROM words, channel i at slice i
//   vga_r, vga_g, vga_b             composed colour, ROM_LAT+2 cycles after the raster inputs
//   blank_n_out                     blank_n delayed to line up with vga_r/g/b
module vga_sprite_engine #(
  parameter int          NSPR    = 4,
  parameter int          SPR_W   = 32,
  parameter int          SPR_H   = 32,
  parameter int          ROM_LAT = 1,
  parameter logic [15:0] KEY     = 16'hF81F
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   chipselect,
  input  logic                                   write,
  input  logic [8:0]                             address,
  input  logic [31:0]                            writedata,
  input  logic [10:0]                            hcount,
  input  logic [9:0]                             vcount,
  input  logic                                   blank_n,
  output logic [NSPR*$clog2(SPR_W*SPR_H)-1:0]    rom_addr,
  input  logic [NSPR*16-1:0]                     rom_data,
  output logic [7:0]                             vga_r,
  output logic [7:0]                             vga_g,
  output logic [7:0]                             vga_b,
  output logic                                   blank_n_out
);

  localparam int AW = $clog2(SPR_W*SPR_H);
  localparam int CB = $clog2(SPR_W);
  localparam int RB = $clog2(SPR_H);

  // Shadow (software-visible) and active (raster-visible) register sets
  logic [10:0] sh_x  [NSPR];
  logic [9:0]  sh_y  [NSPR];
  logic        sh_en [NSPR];
  logic        sh_hf [NSPR];
  logic [10:0] act_x [NSPR];
  logic [9:0]  act_y [NSPR];
  logic        act_en[NSPR];
  logic        act_hf[NSPR];
  logic [23:0] sh_bg;
  logic [23:0] act_bg;

  logic wr_en;
  logic commit;

  assign wr_en  = chipselect & write;
  assign commit = (hcount == 11'd0) && (vcount == 10'd480);

  // The commit copies the pre-write shadow values, so a write landing on the
  // commit cycle only becomes active at the following frame's commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSPR; i++) begin
        sh_x[i]   <= '0;
        sh_y[i]   <= '0;
        sh_en[i]  <= 1'b0;
        sh_hf[i]  <= 1'b0;
        act_x[i]  <= '0;
        act_y[i]  <= '0;
        act_en[i] <= 1'b0;
        act_hf[i] <= 1'b0;
      end
      sh_bg  <= 24'hFFFFFF;
      act_bg <= 24'hFFFFFF;
    end else begin
      if (commit) begin
        for (int i = 0; i < NSPR; i++) begin
          act_x[i]  <= sh_x[i];
          act_y[i]  <= sh_y[i];
          act_en[i] <= sh_en[i];
          act_hf[i] <= sh_hf[i];
        end
        act_bg <= sh_bg;
      end
      if (wr_en) begin
        for (int i = 0; i < NSPR; i++) begin
          if (address == 9'(4*i))   sh_x[i] <= writedata[10:0];
          if (address == 9'(4*i+1)) sh_y[i] <= writedata[9:0];
          if (address == 9'(4*i+2)) begin
            sh_en[i] <= writedata[0];
            sh_hf[i] <= writedata[1];
          end
        end
        if (address == 9'(4*NSPR)) sh_bg <= writedata[23:0];
      end
    end
  end

  // Stage 0: hit test at 12 bits so x+SPR_W never wraps back onto column 0
  logic [11:0]     px12;
  logic [11:0]     ln12;
  logic            on_screen;
  logic [NSPR-1:0] hit_c;
  logic [AW-1:0]   addr_c[NSPR];
  logic [AW-1:0]   addr_q[NSPR];
  logic [15:0]     spr_d [NSPR];

  assign px12      = {2'b00, hcount[10:1]};
  assign ln12      = {2'b00, vcount};
  assign on_screen = (px12 < 12'd640) && (ln12 < 12'd480);

  for (genvar g = 0; g < NSPR; g++) begin : g_ch
    logic [11:0]   x12;
    logic [11:0]   y12;
    logic [CB-1:0] col_raw;
    logic [CB-1:0] col;
    logic [RB-1:0] row;

    assign x12      = {1'b0, act_x[g]};
    assign y12      = {2'b00, act_y[g]};
    assign hit_c[g] = act_en[g] && on_screen &&
                      (px12 >= x12) && (px12 < x12 + 12'(SPR_W)) &&
                      (ln12 >= y12) && (ln12 < y12 + 12'(SPR_H));
    assign col_raw  = CB'(px12 - x12);
    // SPR_W is a power of two, so SPR_W-1-c is the bitwise complement of c
    assign col      = act_hf[g] ? ~col_raw : col_raw;
    assign row      = RB'(ln12 - y12);
    assign addr_c[g] = hit_c[g] ? {row, col} : '0;

    assign rom_addr[g*AW +: AW] = addr_q[g];
    assign spr_d[g]             = rom_data[g*16 +: 16];
  end

  // Index 0 is the stage-0 register; index ROM_LAT lines up with rom_data.
  // Background rides along so a commit cannot recolour pixels already in flight.
  logic [NSPR-1:0] hit_p  [ROM_LAT+1];
  logic            blank_p[ROM_LAT+1];
  logic [23:0]     bg_p   [ROM_LAT+1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSPR; i++) addr_q[i] <= '0;
      for (int k = 0; k <= ROM_LAT; k++) begin
        hit_p[k]   <= '0;
        blank_p[k] <= 1'b0;
        bg_p[k]    <= '0;
      end
    end else begin
      for (int i = 0; i < NSPR; i++) addr_q[i] <= addr_c[i];
      hit_p[0]   <= hit_c;
      blank_p[0] <= blank_n;
      bg_p[0]    <= act_bg;
      for (int k = 1; k <= ROM_LAT; k++) begin
        hit_p[k]   <= hit_p[k-1];
        blank_p[k] <= blank_p[k-1];
        bg_p[k]    <= bg_p[k-1];
      end
    end
  end

  // Compose: scanning downwards lets the lowest-index opaque channel win
  logic [23:0] pix_c;

  always_comb begin
    pix_c = bg_p[ROM_LAT];
    for (int i = NSPR-1; i >= 0; i--) begin
      if (hit_p[ROM_LAT][i] && (spr_d[i] != KEY)) begin
        pix_c = {spr_d[i][15:11], 3'b000, spr_d[i][10:5], 2'b00, spr_d[i][4:0], 3'b000};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      blank_n_out <= 1'b0;
    end else begin
      vga_r       <= blank_p[ROM_LAT] ? pix_c[23:16] : 8'd0;
      vga_g       <= blank_p[ROM_LAT] ? pix_c[15:8]  : 8'd0;
      vga_b       <= blank_p[ROM_LAT] ? pix_c[7:0]   : 8'd0;
      blank_n_out <= blank_p[ROM_LAT];
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, hcount[0], writedata[31:24]};

endmodule

// File: tb/tb_vga_sprite_engine.sv
// tb/tb_vga_sprite_engine.sv - scoreboard bench for vga_sprite_engine
module tb_vga_sprite_engine;

  localparam int          NSPR = 4;
  localparam int          SPR_W = 32;
  localparam int          SPR_H = 32;
  localparam int          LAT  = 1;
  localparam int          AW   = 10;
  localparam logic [15:0] KEY  = 16'hF81F;

  logic                 clk;
  logic                 reset;
  logic                 chipselect;
  logic                 write;
  logic [8:0]           address;
  logic [31:0]          writedata;
  logic [10:0]          hcount;
  logic [9:0]           vcount;
  logic                 blank_n;
  logic [NSPR*AW-1:0]   rom_addr;
  logic [NSPR*16-1:0]   rom_data;
  logic [7:0]           vga_r;
  logic [7:0]           vga_g;
  logic [7:0]           vga_b;
  logic                 blank_n_out;

  vga_sprite_engine #(
    .NSPR(NSPR), .SPR_W(SPR_W), .SPR_H(SPR_H), .ROM_LAT(LAT), .KEY(KEY)
  ) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .hcount(hcount), .vcount(vcount),
    .blank_n(blank_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .blank_n_out(blank_n_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sprite ROM model: word never equals KEY unless the channel is keyed
  bit keyed[NSPR];

  function automatic logic [15:0] rom_word(input int ch, input int a);
    if (keyed[ch]) return KEY;
    return {3'(ch + 1), 3'b101, 10'(a)};
  endfunction

  function automatic logic [NSPR*16-1:0] rom_vec(input logic [NSPR*AW-1:0] ad);
    logic [NSPR*16-1:0] v;
    v = '0;
    for (int c = 0; c < NSPR; c++) v[c*16 +: 16] = rom_word(c, int'(ad[c*AW +: AW]));
    return v;
  endfunction

  logic [NSPR*16-1:0] rom_pipe[LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_vec(rom_addr);
    for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_data = rom_pipe[LAT-1];

  // Reference register model
  int          ax[NSPR], ay[NSPR], sx[NSPR], sy[NSPR];
  bit          aen[NSPR], ahf[NSPR], sen[NSPR], shf[NSPR];
  logic [23:0] abg, sbg;

  task automatic model_reset();
    for (int i = 0; i < NSPR; i++) begin
      ax[i] = 0; ay[i] = 0; aen[i] = 0; ahf[i] = 0;
      sx[i] = 0; sy[i] = 0; sen[i] = 0; shf[i] = 0;
    end
    abg = 24'hFFFFFF;
    sbg = 24'hFFFFFF;
  endtask

  task automatic model_write(input int a, input logic [31:0] d);
    for (int i = 0; i < NSPR; i++) begin
      if (a == 4*i)   sx[i] = int'(d[10:0]);
      if (a == 4*i+1) sy[i] = int'(d[9:0]);
      if (a == 4*i+2) begin sen[i] = d[0]; shf[i] = d[1]; end
    end
    if (a == 4*NSPR) sbg = d[23:0];
  endtask

  function automatic logic [23:0] model_pix(input int px, input int ln);
    for (int i = 0; i < NSPR; i++) begin
      if (aen[i] && px < 640 && ln < 480 && px >= ax[i] && px < ax[i] + SPR_W &&
          ln >= ay[i] && ln < ay[i] + SPR_H) begin
        int col;
        logic [15:0] d;
        col = px - ax[i];
        if (ahf[i]) col = SPR_W - 1 - col;
        d = rom_word(i, (ln - ay[i]) * SPR_W + col);
        if (d != KEY) return {d[15:11], 3'b000, d[10:5], 2'b00, d[4:0], 3'b000};
      end
    end
    return abg;
  endfunction

  typedef struct {
    bit          bn;
    logic [23:0] rgb;
    int          px;
    int          ln;
  } exp_t;

  exp_t q[$];

  task automatic step(input int h, input int v, input bit bn,
                      input bit wr, input int a, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    hcount     = 11'(h);
    vcount     = 10'(v);
    blank_n    = bn;
    chipselect = wr;
    write      = wr;
    address    = 9'(a);
    writedata  = d;
    e.bn  = bn;
    e.rgb = bn ? model_pix(h / 2, v) : 24'h0;
    e.px  = h / 2;
    e.ln  = v;
    q.push_back(e);
    if (h == 0 && v == 480) begin
      for (int i = 0; i < NSPR; i++) begin
        ax[i] = sx[i]; ay[i] = sy[i]; aen[i] = sen[i]; ahf[i] = shf[i];
      end
      abg = sbg;
    end
    if (wr) model_write(a, d);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
    if (q.size() > LAT + 1) begin
      e = q.pop_front();
      check($sformatf("blank(%0d,%0d)", e.px, e.ln), 32'(blank_n_out), 32'(e.bn));
      check($sformatf("rgb(%0d,%0d)", e.px, e.ln), {8'h0, vga_r, vga_g, vga_b}, {8'h0, e.rgb});
    end
  endtask

  task automatic probe(input int px, input int ln);
    step(px * 2, ln, 1'b1, 1'b0, 0, 32'h0);
  endtask

  task automatic reg_wr(input int a, input logic [31:0] d);
    step(0, 600, 1'b0, 1'b1, a, d);
  endtask

  task automatic commit_step();
    step(0, 480, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic drain();
    repeat (LAT + 2) step(0, 600, 1'b0, 1'b0, 0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
    hcount = '0; vcount = '0; blank_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    check("reset_blank", 32'(blank_n_out), 32'h0);
    check("reset_rom_addr", 32'(rom_addr), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // background after reset, then a single sprite at (100,100)
    probe(10, 10);
    reg_wr(0, 100); reg_wr(1, 100); reg_wr(2, 1);
    probe(100, 100);
    commit_step();
    probe(100, 100); probe(99, 100); probe(132, 100); probe(131, 131);

    // overlap priority and colour-key transparency
    reg_wr(0, 200); reg_wr(1, 50);
    reg_wr(4, 200); reg_wr(5, 50); reg_wr(6, 1);
    commit_step();
    probe(205, 60);
    drain();
    keyed[0] = 1'b1;
    probe(205, 60);
    drain();
    keyed[1] = 1'b1;
    probe(205, 60);
    drain();
    keyed[0] = 1'b0;
    keyed[1] = 1'b0;

    // shadow/active double buffering on ch2
    reg_wr(8, 300); reg_wr(9, 10); reg_wr(10, 1);
    commit_step();
    probe(300, 10);
    reg_wr(8, 5);
    probe(300, 10); probe(5, 10);
    commit_step();
    probe(5, 10); probe(300, 10);
    step(0, 480, 1'b0, 1'b1, 8, 300);
    probe(5, 10); probe(300, 10);
    commit_step();
    probe(300, 10); probe(5, 10);

    // hflip address and right-edge clipping on ch3
    reg_wr(12, 0); reg_wr(13, 0); reg_wr(14, 3);
    commit_step();
    probe(0, 0);
    check("rom_addr_hflip", 32'(rom_addr[3*AW +: AW]), SPR_W - 1);
    check("rom_addr_nohit", 32'(rom_addr[0 +: AW]), 32'h0);
    probe(1, 0);
    reg_wr(12, 620); reg_wr(14, 1);
    commit_step();
    probe(620, 0); probe(639, 0); probe(0, 0); probe(10, 5);

    // unmapped/reserved writes, blanking, background change
    reg_wr(4*NSPR + 1, 32'h00123456); reg_wr(3, 32'h7); reg_wr(4*2 + 3, 32'h3);
    commit_step();
    probe(205, 60); probe(10, 100);
    step(410, 60, 1'b0, 1'b0, 0, 32'h0);
    reg_wr(4*NSPR, 32'h00123456);
    commit_step();
    probe(10, 100); probe(205, 60); probe(300, 10); probe(630, 5);

    // asynchronous reset mid-line
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_reset_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    check("async_reset_blank", 32'(blank_n_out), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    model_reset();
    @(posedge clk);
    #1;
    check("post_reset_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    check("post_reset_blank", 32'(blank_n_out), 32'h0);
    probe(205, 60); probe(300, 10);
    commit_step();
    probe(205, 60); probe(630, 5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
